// File: rtl/conv_window_reader.sv
// rtl/conv_window_reader.sv - read-side sequencer assembling sliding KxK windows from the image buffer
//
// Sweeps the IMG_W x IMG_W binary image band by band: for each band it issues
// column addresses 0..IMG_W-1, captures the returned K-bit columns, and shifts
// them into a KxK window that is offered to the convolution engine under a
// valid/ready handshake. Optional feature macro: WIN_POPCNT_EN (adds win_ones).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cal_start       one-cycle pulse, start a frame (ignored and flagged while busy)
//   col_data        buffer column, valid one cycle after data_rd_addr
//   data_rd_addr    buffer column read address
//   conv_row_cnt    current band (top row of the window)
//   win_data        window, bit K*j+k = pixel (win_row+k, win_col+j)
//   win_vld/win_rdy window handshake
//   win_row/win_col window position, win_last marks the final window of a frame
//   busy            frame in progress
//   overrun         sticky, cal_start seen while busy
//   win_ones        (WIN_POPCNT_EN) number of ones in win_data
module conv_window_reader #(
  parameter int IMG_W = 28,
  parameter int K     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cal_start,
  input  logic [K-1:0]   col_data,
  output logic [4:0]     data_rd_addr,
  output logic [4:0]     conv_row_cnt,
  output logic [K*K-1:0] win_data,
  output logic           win_vld,
  input  logic           win_rdy,
  output logic [4:0]     win_row,
  output logic [4:0]     win_col,
  output logic           win_last,
  output logic           busy,
  output logic           overrun
`ifdef WIN_POPCNT_EN
  ,
  output logic [4:0]     win_ones
`endif
);

  localparam logic [4:0] LAST_ADDR = 5'(IMG_W - 1);
  localparam logic [4:0] LAST_BAND = 5'(IMG_W - K);
  localparam logic [4:0] KM1       = 5'(K - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, BWAIT, DRAIN} state_t;

  state_t         state, state_n;
  logic           rd_vld;
  logic           skid_full;
  logic [K-1:0]   skid_data;
  logic [4:0]     col_cnt;

  logic           stall;
  logic           issue;
  logic           capture;
  logic           bwait_done;
  logic [K-1:0]   cap_col;
  logic [K*K-1:0] win_shift;

  assign busy = (state != IDLE);

  always_comb begin
    stall     = win_vld && !win_rdy;
    // Never issue while a column is parked in the skid, so at most one
    // column is ever in flight behind a stalled window.
    issue     = (state == SWEEP) && !skid_full && !stall;
    capture   = !stall && (rd_vld || skid_full);
    // rd_vld and skid_full are never both set: the skid only fills on a
    // stall, and a stall also blocks the issue that would follow it.
    cap_col   = skid_full ? skid_data : col_data;
    win_shift = {cap_col, win_data[K*K-1:K]};
    // Leave BWAIT only once the addr-27 column is absorbed into the window,
    // otherwise a column parked in the skid would be mixed into the next band.
    bwait_done = capture || !(rd_vld || skid_full);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cal_start) state_n = SWEEP;
      SWEEP:   if (issue && data_rd_addr == LAST_ADDR) state_n = BWAIT;
      BWAIT:   if (bwait_done) state_n = (conv_row_cnt == LAST_BAND) ? DRAIN : SWEEP;
      DRAIN:   if (win_vld && win_rdy && win_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

`ifdef WIN_POPCNT_EN
  logic [4:0] ones_n;

  always_comb begin
    ones_n = '0;
    for (int i = 0; i < K*K; i++) begin
      ones_n = ones_n + {4'd0, win_shift[i]};
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_rd_addr <= '0;
      conv_row_cnt <= '0;
      rd_vld       <= 1'b0;
      skid_full    <= 1'b0;
      skid_data    <= '0;
      col_cnt      <= '0;
      win_data     <= '0;
      win_vld      <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      win_last     <= 1'b0;
      overrun      <= 1'b0;
`ifdef WIN_POPCNT_EN
      win_ones     <= '0;
`endif
    end else begin
      rd_vld <= issue;

      if (cal_start && state != IDLE) overrun <= 1'b1;

      if (issue && data_rd_addr != LAST_ADDR) data_rd_addr <= data_rd_addr + 5'd1;

      if (capture) begin
        skid_full <= 1'b0;
      end else if (rd_vld && stall) begin
        skid_full <= 1'b1;
        skid_data <= col_data;
      end

      if (capture) begin
        win_data <= win_shift;
        col_cnt  <= col_cnt + 5'd1;
`ifdef WIN_POPCNT_EN
        win_ones <= ones_n;
`endif
        if (col_cnt >= KM1) begin
          win_vld  <= 1'b1;
          win_row  <= conv_row_cnt;
          win_col  <= col_cnt - KM1;
          win_last <= (conv_row_cnt == LAST_BAND) && (col_cnt == LAST_ADDR);
        end else begin
          win_vld  <= 1'b0;
          win_last <= 1'b0;
        end
      end else if (win_vld && win_rdy) begin
        win_vld  <= 1'b0;
        win_last <= 1'b0;
      end

      // Band bookkeeping comes last so the column-count clear overrides the
      // increment of the addr-27 capture that completes the band.
      if (state == IDLE && cal_start) begin
        data_rd_addr <= '0;
        conv_row_cnt <= '0;
        col_cnt      <= '0;
      end else if (state == BWAIT && bwait_done) begin
        data_rd_addr <= '0;
        col_cnt      <= '0;
        if (conv_row_cnt != LAST_BAND) conv_row_cnt <= conv_row_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// tb/tb_conv_window_reader.sv - directed self-checking bench for conv_window_reader
module tb_conv_window_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cal_start;
  logic [4:0]  col_data;
  logic [4:0]  data_rd_addr;
  logic [4:0]  conv_row_cnt;
  logic [24:0] win_data;
  logic        win_vld;
  logic        win_rdy;
  logic [4:0]  win_row;
  logic [4:0]  win_col;
  logic        win_last;
  logic        busy;
  logic        overrun;
`ifdef WIN_POPCNT_EN
  logic [4:0]  win_ones;
`endif

  conv_window_reader #(.IMG_W(28), .K(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cal_start    (cal_start),
    .col_data     (col_data),
    .data_rd_addr (data_rd_addr),
    .conv_row_cnt (conv_row_cnt),
    .win_data     (win_data),
    .win_vld      (win_vld),
    .win_rdy      (win_rdy),
    .win_row      (win_row),
    .win_col      (win_col),
    .win_last     (win_last),
    .busy         (busy),
    .overrun      (overrun)
`ifdef WIN_POPCNT_EN
    ,
    .win_ones     (win_ones)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit img [0:27][0:27];

  function automatic logic [24:0] model_win(input int r, input int c);
    logic [24:0] m;
    m = '0;
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 5; k++)
        m[5*j+k] = img[r+k][c+j];
    return m;
  endfunction

  function automatic logic [4:0] buf_col(input int band, input int addr);
    logic [4:0] v;
    v = '0;
    for (int k = 0; k < 5; k++)
      if (band + k < 28 && addr < 28) v[k] = img[band+k][addr];
    return v;
  endfunction

  task automatic set_image(input int kind);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        case (kind)
          0:       img[r][c] = 1'((r + c) % 2);
          1:       img[r][c] = (r == 10 && c == 12);
          default: img[r][c] = 1'($urandom_range(0, 1));
        endcase
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Image buffer: registered read, data for the address seen this cycle appears next cycle.
  logic [4:0] pend;
  initial begin
    col_data = '0;
    forever begin
      @(negedge clk);
      pend = buf_col(int'(conv_row_cnt), int'(data_rd_addr));
      @(posedge clk);
      #1 col_data = pend;
    end
  end

  bit rdy_rand  = 1'b0;
  bit rdy_force = 1'b1;
  initial begin
    win_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 win_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  bit          mon_en = 1'b0;
  int          n_win, first_cyc, last_cyc, nz_cnt;
  logic [24:0] first_data, pix_data;
  logic [4:0]  pix_ones;
  bit          hold_prev;
  logic [34:0] snap;

  task automatic reset_mon();
    n_win      = 0;
    first_cyc  = -1;
    last_cyc   = -1;
    nz_cnt     = 0;
    first_data = '1;
    pix_data   = '1;
    pix_ones   = '1;
    hold_prev  = 1'b0;
    mon_en     = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) check("hold_stable", {win_row, win_col, win_data}, snap);
      if (win_vld && win_rdy) begin
        if (n_win < 576) begin
          int r, c;
          logic [24:0] e;
          r = n_win / 24;
          c = n_win % 24;
          e = model_win(r, c);
          check("win_pos", {win_row, win_col}, {r[4:0], c[4:0]});
          check("win_data", win_data, e);
          check("win_last", win_last, n_win == 575);
`ifdef WIN_POPCNT_EN
          check("win_ones", win_ones, $countones(e));
          if (r == 10 && c == 12) pix_ones = win_ones;
`endif
          if (n_win == 0) begin
            first_cyc  = cyc;
            first_data = win_data;
          end
          if (win_last) last_cyc = cyc;
          if (win_data != 0) nz_cnt++;
          if (r == 10 && c == 12) pix_data = win_data;
        end else begin
          check("win_extra", n_win, 575);
        end
        n_win++;
      end
      hold_prev = win_vld && !win_rdy;
      snap      = {win_row, win_col, win_data};
    end
  end

  task automatic start_frame(output int t);
    @(posedge clk);
    #1 cal_start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 cal_start = 1'b0;
  endtask

  task automatic wait_idle(input int t, output int low_cyc);
    do begin
      @(negedge clk);
      if (cyc == t + 1) check("busy_at_start", busy, 1);
    end while ((busy || cyc <= t + 1) && cyc < t + 8000);
    low_cyc = cyc;
    check("frame_done", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, data_rd_addr, 0);
    check({tag, "_band"}, conv_row_cnt, 0);
    check({tag, "_data"}, win_data, 0);
    check({tag, "_vld"}, win_vld, 0);
    check({tag, "_row"}, win_row, 0);
    check({tag, "_col"}, win_col, 0);
    check({tag, "_last"}, win_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic wait_window(input int row, input int col, input int t);
    do @(negedge clk);
    while (!(win_vld && win_row == row && win_col == col) && cyc < t + 8000);
    check("reach_window", {win_vld, win_row, win_col}, {1'b1, row[4:0], col[4:0]});
  endtask

  int t0, tlow;
  logic [4:0] addr_hold;

  initial begin
    rst_n     = 1'b0;
    cal_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // Checkerboard, always ready: exact timing of first/last window and busy.
    set_image(0);
    reset_mon();
    start_frame(t0);
    wait_idle(t0, tlow);
    check("cb_count", n_win, 576);
    check("cb_first_cyc", first_cyc, t0 + 7);
    check("cb_first_data", first_data, 25'h0AAAAAA);
    check("cb_last_cyc", last_cyc, t0 + 697);
    check("cb_busy_low", tlow, t0 + 698);
    check("cb_overrun", overrun, 0);

    // Single set pixel at (10,12).
    set_image(1);
    reset_mon();
    start_frame(t0);
    wait_idle(t0, tlow);
    check("px_count", n_win, 576);
    check("px_nonzero", nz_cnt, 25);
    check("px_data", pix_data, 25'h0000001);
`ifdef WIN_POPCNT_EN
    check("px_ones", pix_ones, 1);
`endif

    // Random image with random backpressure.
    set_image(2);
    reset_mon();
    rdy_rand = 1'b1;
    start_frame(t0);
    wait_idle(t0, tlow);
    rdy_rand = 1'b0;
    check("rnd_count", n_win, 576);

    // cal_start during band 5 is flagged and otherwise ignored.
    set_image(0);
    reset_mon();
    start_frame(t0);
    do @(negedge clk); while (conv_row_cnt != 5 && cyc < t0 + 8000);
    check("ov_band", conv_row_cnt, 5);
    @(posedge clk);
    #1 cal_start = 1'b1;
    @(posedge clk);
    #1 cal_start = 1'b0;
    wait_idle(t0, tlow);
    check("ov_flag", overrun, 1);
    check("ov_count", n_win, 576);
    reset_mon();
    start_frame(t0);
    wait_idle(t0, tlow);
    check("ov2_count", n_win, 576);
    check("ov2_last_cyc", last_cyc, t0 + 697);
    check("ov2_sticky", overrun, 1);

    // Reset in the middle of band 12.
    reset_mon();
    start_frame(t0);
    wait_window(12, 7, t0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    reset_mon();
    start_frame(t0);
    wait_idle(t0, tlow);
    check("rst_count", n_win, 576);
    check("rst_first_cyc", first_cyc, t0 + 7);

    // Long stall at band 3 col 20: one window held, issue stops, nothing lost.
    set_image(2);
    reset_mon();
    start_frame(t0);
    wait_window(3, 20, t0);
    rdy_force = 1'b0;
    repeat (3) @(negedge clk);
    addr_hold = data_rd_addr;
    repeat (47) @(negedge clk);
    check("stall_addr_frozen", data_rd_addr, addr_hold);
    check("stall_held_win", {win_vld, win_row, win_col}, {1'b1, 5'd3, 5'd21});
    rdy_force = 1'b1;
    wait_idle(t0, tlow);
    check("stall_count", n_win, 576);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
